lcd_host: RTL and testbench

LCD_HOST -- requirements
Module: lcd_host

---
 rtl/lcd_host.sv | 152 +++++++++++++++
 tb/tb_lcd_host.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_host.sv
// Host-side harness for an LCD image controller: image ROM, command FIFO, result RAM.
// Optional watchdog on the sequencer is enabled by defining LCD_HOST_WDOG_EN.
module lcd_host (
    input  logic       clk,
    input  logic       reset,
    input  logic       img_we,
    input  logic [5:0] img_addr,
    input  logic [7:0] img_wdata,
    input  logic       cq_push,
    input  logic [3:0] cq_cmd,
    output logic       cq_full,
    input  logic       start,
    output logic [3:0] cmd,
    output logic       cmd_valid,
    input  logic       busy,
    input  logic       done,
    input  logic       IROM_rd,
    input  logic [5:0] IROM_A,
    output logic [7:0] IROM_Q,
    input  logic       IRAM_valid,
    input  logic [5:0] IRAM_A,
    input  logic [7:0] IRAM_D,
    input  logic [5:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       finished,
    output logic [6:0] wr_count,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        ISSUE,
        GUARD,
        CAPTURE,
        FINISH
    } state_t;

    state_t state, state_n;

    logic [7:0] rom [64];
    logic [7:0] ram [64];

    logic [3:0] fifo_q [16];
    logic [3:0] wr_ptr, rd_ptr;
    logic [4:0] count;
    logic [3:0] head;
    logic       fifo_empty;
    logic       push_ok;
    logic       pop;
    logic       flush;
    logic       wdog_trip;

    assign head       = fifo_q[rd_ptr];
    assign fifo_empty = (count == 5'd0);
    assign cq_full    = (count == 5'd16);
    assign push_ok    = cq_push && !cq_full && (cq_cmd <= 4'hB);
    assign pop        = (state == ISSUE);
    assign flush      = pop && (head == 4'h0);

    assign cmd_valid  = (state == ISSUE);
    assign cmd        = cmd_valid ? head : 4'h0;
    assign finished   = (state == FINISH);

    assign IROM_Q  = IROM_rd ? rom[IROM_A] : 8'd0;
    assign rd_data = ram[rd_addr];

`ifdef LCD_HOST_WDOG_EN
    logic [9:0] wdog;
    logic       wdog_on;

    assign wdog_on = (state == WAIT_RDY) || (state == GUARD) ||
                     (state == CAPTURE);
`endif

    always_comb begin
        state_n   = state;
        wdog_trip = 1'b0;
        unique case (state)
            IDLE:     if (start) state_n = WAIT_RDY;
            WAIT_RDY: if (!busy && !fifo_empty) state_n = ISSUE;
            ISSUE:    state_n = (head == 4'h0) ? CAPTURE : GUARD;
            GUARD:    state_n = WAIT_RDY;
            CAPTURE:  if (done) state_n = FINISH;
            FINISH:   state_n = FINISH;
            default:  state_n = IDLE;
        endcase
`ifdef LCD_HOST_WDOG_EN
        if (wdog_on && wdog == 10'h3FF) begin
            state_n   = FINISH;
            wdog_trip = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

`ifdef LCD_HOST_WDOG_EN
    // Restarts on every state change so only a genuine stall trips it.
    always_ff @(posedge clk) begin
        if (reset || !wdog_on || state_n != state) wdog <= 10'd0;
        else                                       wdog <= wdog + 10'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 4'd0;
            rd_ptr <= 4'd0;
            count  <= 5'd0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= 5'd0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 4'd1;
            if (pop)     rd_ptr <= rd_ptr + 4'd1;
            count <= count + 5'(push_ok) - 5'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_q[wr_ptr] <= cq_cmd;
    end

    always_ff @(posedge clk) begin
        if (img_we)     rom[img_addr] <= img_wdata;
        if (IRAM_valid) ram[IRAM_A]   <= IRAM_D;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_count <= 7'd0;
        end else if (IRAM_valid && wr_count != 7'd64) begin
            wr_count <= wr_count + 7'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if ((cq_push && !push_ok) ||
                     (IRAM_valid && state != CAPTURE) ||
                     (state == CAPTURE && done && wr_count != 7'd64) ||
                     wdog_trip) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lcd_host.sv
// Directed self-checking bench for lcd_host.
module tb_lcd_host;

    logic       clk = 1'b0;
    logic       reset;
    logic       img_we;
    logic [5:0] img_addr;
    logic [7:0] img_wdata;
    logic       cq_push;
    logic [3:0] cq_cmd;
    logic       cq_full;
    logic       start;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       busy;
    logic       done;
    logic       IROM_rd;
    logic [5:0] IROM_A;
    logic [7:0] IROM_Q;
    logic       IRAM_valid;
    logic [5:0] IRAM_A;
    logic [7:0] IRAM_D;
    logic [5:0] rd_addr;
    logic [7:0] rd_data;
    logic       finished;
    logic [6:0] wr_count;
    logic       err;

    int tests = 0;
    int fails = 0;

    lcd_host dut (
        .clk(clk), .reset(reset),
        .img_we(img_we), .img_addr(img_addr), .img_wdata(img_wdata),
        .cq_push(cq_push), .cq_cmd(cq_cmd), .cq_full(cq_full),
        .start(start), .cmd(cmd), .cmd_valid(cmd_valid),
        .busy(busy), .done(done),
        .IROM_rd(IROM_rd), .IROM_A(IROM_A), .IROM_Q(IROM_Q),
        .IRAM_valid(IRAM_valid), .IRAM_A(IRAM_A), .IRAM_D(IRAM_D),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .finished(finished), .wr_count(wr_count), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        img_we = 0; img_addr = 0; img_wdata = 0;
        cq_push = 0; cq_cmd = 0; start = 0;
        busy = 0; done = 0; IROM_rd = 0; IROM_A = 0;
        IRAM_valid = 0; IRAM_A = 0; IRAM_D = 0; rd_addr = 0;
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic push(input logic [3:0] v);
        cq_push = 1;
        cq_cmd  = v;
        tick();
        cq_push = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic wait_pulse(input int bound, output logic seen,
                              output logic [3:0] c);
        seen = 0;
        c    = 4'h0;
        for (int i = 0; i < bound && !seen; i++) begin
            tick();
            if (cmd_valid) begin
                seen = 1;
                c    = cmd;
            end
        end
    endtask

    task automatic count_pulses(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (cmd_valid) n++;
        end
    endtask

    initial begin
        logic       seen;
        logic [3:0] c;
        int         n;
        int         bad;
        int         last;
        logic [3:0] got [$];
        int         at [$];

        // reset state
        do_reset();
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd", cmd, 0);
        chk("rst_finished", finished, 0);
        chk("rst_wr_count", wr_count, 0);
        chk("rst_err", err, 0);
        chk("rst_cq_full", cq_full, 0);

        // full image run
        for (int i = 0; i < 64; i++) begin
            img_we = 1; img_addr = 6'(i); img_wdata = 8'(i);
            tick();
        end
        img_we = 0;
        push(4'h0);
        pulse_start();
        wait_pulse(10, seen, c);
        chk("run_issue_seen", seen, 1);
        chk("run_issue_cmd", c, 4'h0);
        tick();
        chk("run_single_pulse", cmd_valid, 0);
        IROM_rd = 0; IROM_A = 6'd5;
        #1;
        chk("irom_q_idle", IROM_Q, 0);
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            IROM_rd = 1; IROM_A = 6'(i);
            #1;
            if (IROM_Q !== 8'(i)) bad++;
            tick();
        end
        IROM_rd = 0;
        chk("irom_q_reads_bad", bad, 0);
        for (int i = 0; i < 64; i++) begin
            IRAM_valid = 1; IRAM_A = 6'(i); IRAM_D = 8'(i);
            tick();
        end
        IRAM_valid = 0;
        chk("run_wr_count", wr_count, 64);
        chk("run_err_pre", err, 0);
        done = 1;
        tick();
        done = 0;
        chk("run_finished", finished, 1);
        chk("run_err", err, 0);
        rd_addr = 6'd0;  #1; chk("ram0", rd_data, 8'd0);
        rd_addr = 6'd37; #1; chk("ram37", rd_data, 8'd37);
        rd_addr = 6'd63; #1; chk("ram63", rd_data, 8'd63);
        IRAM_valid = 1; IRAM_A = 6'd1; IRAM_D = 8'hEE;
        tick();
        IRAM_valid = 0;
        chk("wr_count_sat", wr_count, 64);
        chk("late_write_err", err, 1);
        chk("finish_holds", finished, 1);

        // busy gating and guard spacing
        do_reset();
        push(4'h1); push(4'h5); push(4'h0);
        busy = 1;
        pulse_start();
        count_pulses(70, n);
        chk("busy_no_issue", n, 0);
        busy = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cmd_valid) begin
                got.push_back(cmd);
                at.push_back(i);
            end
        end
        chk("busy_pulse_count", got.size(), 3);
        if (got.size() == 3) begin
            chk("seq0", got[0], 4'h1);
            chk("seq1", got[1], 4'h5);
            chk("seq2", got[2], 4'h0);
            chk("gap01", at[1] - at[0], 3);
            chk("gap12", at[2] - at[1], 3);
        end

        // overflow: 17 pushes
        do_reset();
        for (int i = 0; i < 16; i++) push(4'((i % 11) + 1));
        chk("full_after16", cq_full, 1);
        chk("err_after16", err, 0);
        push(4'h7);
        chk("full_after17", cq_full, 1);
        chk("err_after17", err, 1);
        pulse_start();
        got.delete();
        for (int i = 0; i < 70; i++) begin
            tick();
            if (cmd_valid) got.push_back(cmd);
        end
        chk("ovf_issued", got.size(), 16);
        bad = 0;
        for (int i = 0; i < got.size(); i++)
            if (got[i] !== 4'((i % 11) + 1)) bad++;
        chk("ovf_order_bad", bad, 0);

        // illegal code dropped, 4'hB accepted
        do_reset();
        push(4'hC);
        chk("illegal_err", err, 1);
        chk("illegal_full", cq_full, 0);
        push(4'hB);
        pulse_start();
        wait_pulse(10, seen, c);
        chk("b_seen", seen, 1);
        chk("b_cmd", c, 4'hB);

        // flush after cmd 0
        do_reset();
        push(4'h0); push(4'h1);
        pulse_start();
        wait_pulse(10, seen, c);
        chk("flush_seen", seen, 1);
        chk("flush_cmd", c, 4'h0);
        count_pulses(20, n);
        chk("flush_no_more", n, 0);

        // early done
        do_reset();
        push(4'h0);
        pulse_start();
        wait_pulse(10, seen, c);
        tick();
        for (int i = 0; i < 10; i++) begin
            IRAM_valid = 1; IRAM_A = 6'(i); IRAM_D = 8'hA0;
            tick();
        end
        IRAM_valid = 0;
        chk("early_err_pre", err, 0);
        done = 1;
        tick();
        done = 0;
        chk("early_finished", finished, 1);
        chk("early_wr_count", wr_count, 10);
        chk("early_err", err, 1);

        // write outside CAPTURE
        do_reset();
        IRAM_valid = 1; IRAM_A = 6'd9; IRAM_D = 8'h5A;
        tick();
        IRAM_valid = 0;
        chk("idle_write_err", err, 1);
        chk("idle_write_cnt", wr_count, 1);
        rd_addr = 6'd9; #1;
        chk("idle_write_data", rd_data, 8'h5A);

        // reset mid-run aborts
        do_reset();
        push(4'h1); push(4'h5);
        pulse_start();
        wait_pulse(10, seen, c);
        chk("abort_first", c, 4'h1);
        reset = 1;
        tick();
        reset = 0;
        chk("abort_valid", cmd_valid, 0);
        count_pulses(20, n);
        chk("abort_no_more", n, 0);

        // stall with busy held
        do_reset();
        push(4'h1);
        busy = 1;
        pulse_start();
        last = 0;
        for (int i = 0; i < 1100; i++) begin
            tick();
            if (finished && last == 0) last = i + 1;
        end
`ifdef LCD_HOST_WDOG_EN
        chk("wdog_finished", finished, 1);
        chk("wdog_err", err, 1);
`else
        chk("nowdog_finished", finished, 0);
        chk("nowdog_err", err, 0);
`endif
        busy = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
